// File: rtl/apb_periph_demux.sv
// rtl/apb_periph_demux.sv - APB one-to-many demux with registered request path, decode/timeout errors and sticky error capture
// Optional watchdog compiled in with APB_DEMUX_TIMEOUT_EN.
module apb_periph_demux #(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             s_psel_i,
    input  logic                             s_penable_i,
    input  logic                             s_pwrite_i,
    input  logic [ADDR_WIDTH-1:0]            s_paddr_i,
    input  logic [DATA_WIDTH-1:0]            s_pwdata_i,
    output logic [DATA_WIDTH-1:0]            s_prdata_o,
    output logic                             s_pready_o,
    output logic                             s_pslverr_o,
    output logic [NUM_SLAVES-1:0]            m_psel_o,
    output logic                             m_penable_o,
    output logic                             m_pwrite_o,
    output logic [ADDR_WIDTH-1:0]            m_paddr_o,
    output logic [DATA_WIDTH-1:0]            m_pwdata_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NUM_SLAVES-1:0]            m_pready_i,
    input  logic [NUM_SLAVES-1:0]            m_pslverr_i,
    output logic                             err_valid_o,
    output logic [1:0]                       err_code_o,
    output logic [ADDR_WIDTH-1:0]            err_addr_o,
    input  logic                             err_clr_i
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_periph_demux: illegal NUM_SLAVES or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic                   pwrite_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic                   rsp_err_q;
    logic                   err_valid_q;
    logic [1:0]             err_code_q;
    logic [ADDR_WIDTH-1:0]  err_addr_q;

    logic                   setup_req;
    logic                   hit_any;
    logic [SEL_W-1:0]       hit_idx;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   sel_ready;
    logic                   sel_err;
    logic                   miss_evt;
    logic                   timeout_hit;

    assign setup_req = s_psel_i && !s_penable_i;
    assign miss_evt  = (state_q == IDLE) && setup_req && !hit_any;

    // Walk from the top index down so the lowest-index hit wins on overlap.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((s_paddr_i & SLV_MASK[i]) == SLV_BASE[i]) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_rdata = m_prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ready = m_pready_i[i];
                sel_err   = m_pslverr_i[i];
            end
        end
    end

`ifdef APB_DEMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt_q + 1'b1;
    // A ready arriving on the limit cycle takes priority over the abort.
    assign timeout_hit  = (state_q == M_ACCESS) && !sel_ready &&
                          (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if ((state_q == IDLE) && setup_req && hit_any) begin
            wait_cnt_q <= '0;
        end else if (state_q == M_ACCESS) begin
            wait_cnt_q <= wait_cnt_inc;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_pready_o  = 1'b0;
        s_pslverr_o = 1'b0;
        s_prdata_o  = '0;
        m_psel_o    = '0;
        m_penable_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup_req) begin
                    state_d = hit_any ? M_SETUP : RESP;
                end
            end
            M_SETUP: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    m_psel_o[i] = (sel_q == SEL_W'(i));
                end
                state_d = M_ACCESS;
            end
            M_ACCESS: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    m_psel_o[i] = (sel_q == SEL_W'(i));
                end
                m_penable_o = 1'b1;
                if (sel_ready || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                s_pready_o  = 1'b1;
                s_pslverr_o = rsp_err_q;
                s_prdata_o  = rsp_data_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q      <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup_req) begin
                        sel_q      <= hit_idx;
                        paddr_q    <= s_paddr_i;
                        pwdata_q   <= s_pwdata_i;
                        pwrite_q   <= s_pwrite_i;
                        rsp_data_q <= '0;
                        rsp_err_q  <= !hit_any;
                    end
                end
                M_ACCESS: begin
                    if (sel_ready) begin
                        rsp_data_q <= pwrite_q ? '0 : sel_rdata;
                        rsp_err_q  <= sel_err;
                    end else if (timeout_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new error beats a same-cycle clear; otherwise the first capture sticks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_addr_q  <= '0;
        end else if ((miss_evt || timeout_hit) && (!err_valid_q || err_clr_i)) begin
            err_valid_q <= 1'b1;
            err_code_q  <= timeout_hit ? 2'b10 : 2'b01;
            err_addr_q  <= miss_evt ? s_paddr_i : paddr_q;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_addr_q  <= '0;
        end
    end

    assign m_paddr_o   = paddr_q;
    assign m_pwdata_o  = pwdata_q;
    assign m_pwrite_o  = pwrite_q;
    assign err_valid_o = err_valid_q;
    assign err_code_o  = err_code_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_apb_periph_demux.sv
// tb/tb_apb_periph_demux.sv - directed self-checking bench for apb_periph_demux
module tb_apb_periph_demux;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         s_psel_i, s_penable_i, s_pwrite_i;
    logic [31:0]  s_paddr_i, s_pwdata_i;
    logic [31:0]  s_prdata_o;
    logic         s_pready_o, s_pslverr_o;
    logic [3:0]   m_psel_o;
    logic         m_penable_o, m_pwrite_o;
    logic [31:0]  m_paddr_o, m_pwdata_o;
    logic [127:0] m_prdata_i;
    logic [3:0]   m_pready_i, m_pslverr_i;
    logic         err_valid_o;
    logic [1:0]   err_code_o;
    logic [31:0]  err_addr_o;
    logic         err_clr_i;

    int n_cmp = 0;
    int n_err = 0;
    int wait_cfg [4];
    int acc_cnt = 0;

    always #5 clk_i = ~clk_i;

    apb_periph_demux #(
        .NUM_SLAVES     (4),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SLV_BASE       ({32'h1A10_0000, 32'h1A10_2000, 32'h1A10_3000, 32'h1A10_0000}),
        .SLV_MASK       ({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_psel_i    (s_psel_i),
        .s_penable_i (s_penable_i),
        .s_pwrite_i  (s_pwrite_i),
        .s_paddr_i   (s_paddr_i),
        .s_pwdata_i  (s_pwdata_i),
        .s_prdata_o  (s_prdata_o),
        .s_pready_o  (s_pready_o),
        .s_pslverr_o (s_pslverr_o),
        .m_psel_o    (m_psel_o),
        .m_penable_o (m_penable_o),
        .m_pwrite_o  (m_pwrite_o),
        .m_paddr_o   (m_paddr_o),
        .m_pwdata_o  (m_pwdata_o),
        .m_prdata_i  (m_prdata_i),
        .m_pready_i  (m_pready_i),
        .m_pslverr_i (m_pslverr_i),
        .err_valid_o (err_valid_o),
        .err_code_o  (err_code_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr_i)
    );

    // Slave model: ready once the access phase has lasted wait_cfg[i] extra cycles.
    always @(posedge clk_i) acc_cnt <= m_penable_o ? acc_cnt + 1 : 0;

    always_comb begin
        m_pready_i = '0;
        for (int i = 0; i < 4; i++) begin
            m_pready_i[i] = m_psel_o[i] && m_penable_o && (acc_cnt >= wait_cfg[i]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic clr, output logic [31:0] rdata, output logic err,
                            output int cyc, output logic [3:0] psel_or);
        s_psel_i    = 1'b1;
        s_penable_i = 1'b0;
        s_paddr_i   = addr;
        s_pwrite_i  = wr;
        s_pwdata_i  = wdata;
        err_clr_i   = clr;
        @(posedge clk_i); #1;
        err_clr_i   = 1'b0;
        s_penable_i = 1'b1;
        cyc     = 1;
        psel_or = '0;
        while (!s_pready_o && cyc < 50) begin
            psel_or |= m_psel_o;
            @(posedge clk_i); #1;
            cyc++;
        end
        psel_or |= m_psel_o;
        rdata = s_prdata_o;
        err   = s_pslverr_o;
        @(posedge clk_i); #1;
        s_psel_i    = 1'b0;
        s_penable_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cy;
    logic [3:0]  ps;

    initial begin
        rst_i = 1'b1;
        s_psel_i = 1'b0; s_penable_i = 1'b0; s_pwrite_i = 1'b0;
        s_paddr_i = '0; s_pwdata_i = '0; err_clr_i = 1'b0;
        m_pslverr_i = '0;
        m_prdata_i = {32'h3333_3333, 32'hCAFE_0001, 32'h1111_0001, 32'h0000_AAAA};
        for (int i = 0; i < 4; i++) wait_cfg[i] = 0;

        @(posedge clk_i); @(posedge clk_i); #1;
        chk("rst_pready",  s_pready_o, 0);
        chk("rst_pslverr", s_pslverr_o, 0);
        chk("rst_prdata",  s_prdata_o, 0);
        chk("rst_psel",    m_psel_o, 0);
        chk("rst_penable", m_penable_o, 0);
        chk("rst_paddr",   m_paddr_o, 0);
        chk("rst_errv",    err_valid_o, 0);
        chk("rst_errc",    err_code_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Zero-wait read from slave 2, with in-cycle downstream checks.
        s_psel_i = 1'b1; s_penable_i = 1'b0; s_pwrite_i = 1'b0; s_paddr_i = 32'h1A10_2004;
        @(posedge clk_i); #1;
        s_penable_i = 1'b1;
        chk("c1_psel",    m_psel_o, 4'b0100);
        chk("c1_penable", m_penable_o, 0);
        chk("c1_pready",  s_pready_o, 0);
        chk("c1_paddr",   m_paddr_o, 32'h1A10_2004);
        @(posedge clk_i); #1;
        chk("c2_psel",    m_psel_o, 4'b0100);
        chk("c2_penable", m_penable_o, 1);
        chk("c2_pready",  s_pready_o, 0);
        @(posedge clk_i); #1;
        chk("c3_pready",  s_pready_o, 1);
        chk("c3_prdata",  s_prdata_o, 32'hCAFE_0001);
        chk("c3_pslverr", s_pslverr_o, 0);
        chk("c3_psel",    m_psel_o, 0);
        @(posedge clk_i); #1;
        s_psel_i = 1'b0; s_penable_i = 1'b0;
        chk("c4_pready",  s_pready_o, 0);

        // Overlap: slaves 1 and 3 both hit, lowest index wins.
        apb_xfer(32'h1A10_3000, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("ovl_psel",  ps, 4'b0010);
        chk("ovl_rdata", rd, 32'h1111_0001);
        chk("ovl_cyc",   cy, 3);

        // Write to slave 0 back-to-back: no data returned.
        apb_xfer(32'h1A10_0008, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, er, cy, ps);
        chk("wr_psel",   ps, 4'b0001);
        chk("wr_rdata",  rd, 32'h0);
        chk("wr_err",    er, 0);
        chk("wr_pwdata", m_pwdata_o, 32'hDEAD_BEEF);
        chk("wr_pwrite", m_pwrite_o, 1);

        // Downstream slverr is forwarded but not logged.
        m_pslverr_i = 4'b0100;
        apb_xfer(32'h1A10_2010, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("slverr_err",   er, 1);
        chk("slverr_rdata", rd, 32'hCAFE_0001);
        chk("slverr_errv",  err_valid_o, 0);
        m_pslverr_i = '0;

        // One downstream wait state adds one cycle.
        wait_cfg[1] = 1;
        apb_xfer(32'h1A10_3010, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("wait1_cyc",   cy, 4);
        chk("wait1_rdata", rd, 32'h1111_0001);
        wait_cfg[1] = 0;

        // Unmapped write.
        apb_xfer(32'h0000_0010, 1'b1, 32'h1234_5678, 1'b0, rd, er, cy, ps);
        chk("miss_cyc",   cy, 1);
        chk("miss_err",   er, 1);
        chk("miss_rdata", rd, 0);
        chk("miss_psel",  ps, 0);
        chk("miss_errv",  err_valid_o, 1);
        chk("miss_errc",  err_code_o, 2'b01);
        chk("miss_erra",  err_addr_o, 32'h0000_0010);

        // Second error must not overwrite.
        apb_xfer(32'h0000_0030, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("miss2_err",  er, 1);
        chk("miss2_erra", err_addr_o, 32'h0000_0010);

        // Clear coincident with new miss: new error captured.
        apb_xfer(32'h0000_0020, 1'b0, 32'h0, 1'b1, rd, er, cy, ps);
        chk("clrmiss_errv", err_valid_o, 1);
        chk("clrmiss_erra", err_addr_o, 32'h0000_0020);

        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        chk("clr_errv", err_valid_o, 0);
        chk("clr_errc", err_code_o, 0);
        chk("clr_erra", err_addr_o, 0);

`ifdef APB_DEMUX_TIMEOUT_EN
        wait_cfg[0] = 1000;
        apb_xfer(32'h1A10_0000, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("to_cyc",   cy, 6);
        chk("to_err",   er, 1);
        chk("to_rdata", rd, 0);
        chk("to_errc",  err_code_o, 2'b10);
        chk("to_erra",  err_addr_o, 32'h1A10_0000);
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        wait_cfg[0] = 3;
        apb_xfer(32'h1A10_0004, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("late_cyc",   cy, 6);
        chk("late_err",   er, 0);
        chk("late_rdata", rd, 32'h0000_AAAA);
        chk("late_errv",  err_valid_o, 0);
`else
        wait_cfg[0] = 6;
        apb_xfer(32'h1A10_0000, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("nowd_cyc",   cy, 9);
        chk("nowd_err",   er, 0);
        chk("nowd_rdata", rd, 32'h0000_AAAA);
        chk("nowd_errv",  err_valid_o, 0);
`endif
        wait_cfg[0] = 0;

        // Reset during M_ACCESS, with an error captured beforehand.
        apb_xfer(32'h0000_0040, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("pre_rst_errv", err_valid_o, 1);
        wait_cfg[2] = 1000;
        s_psel_i = 1'b1; s_penable_i = 1'b0; s_pwrite_i = 1'b0; s_paddr_i = 32'h1A10_2000;
        @(posedge clk_i); #1;
        s_penable_i = 1'b1;
        @(posedge clk_i); #1;
        chk("macc_penable", m_penable_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        s_psel_i = 1'b0; s_penable_i = 1'b0;
        chk("mrst_psel",    m_psel_o, 0);
        chk("mrst_penable", m_penable_o, 0);
        chk("mrst_pready",  s_pready_o, 0);
        chk("mrst_paddr",   m_paddr_o, 0);
        chk("mrst_errv",    err_valid_o, 0);
        wait_cfg[2] = 0;
        apb_xfer(32'h1A10_2004, 1'b0, 32'h0, 1'b0, rd, er, cy, ps);
        chk("post_rst_cyc",   cy, 3);
        chk("post_rst_rdata", rd, 32'hCAFE_0001);
        chk("post_rst_err",   er, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
